tx_rate_scheduler: RTL

Multi-stream rate scheduler sharing one frame generator between NUM_STREAMS traffic streams. Each stream has a programmable inter-frame period (integer cycles plus binary fraction) that accrues transmit credits. A round-robin arbiter converts credits into grants on a valid/ready interface towards the frame generator.

---
 rtl/tx_rate_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tx_rate_scheduler.sv
// Multi-stream rate scheduler: fractional-period credit accrual per stream and a
// round-robin grant arbiter. Define TX_SCHED_OVERFLOW_EN to build sticky overflow flags.
module tx_rate_scheduler #(
    parameter int NUM_STREAMS  = 4,
    parameter int PERIOD_WIDTH = 16,
    parameter int FRAC_WIDTH   = 4,
    parameter int CREDIT_MAX   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_STREAMS)-1:0] cfg_stream,
    input  logic                           cfg_enable,
    input  logic [PERIOD_WIDTH-1:0]        cfg_period,
    input  logic [FRAC_WIDTH-1:0]          cfg_frac,
    output logic                           grant_valid,
    output logic [$clog2(NUM_STREAMS)-1:0] grant_stream,
    input  logic                           grant_ready,
    output logic [NUM_STREAMS-1:0]         overflow
);
    localparam int SW = $clog2(NUM_STREAMS);
    localparam int CW = $clog2(CREDIT_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_reg;
    logic            grant_valid_reg;
    logic [SW-1:0]   grant_stream_reg;
    logic [SW-1:0]   rr_ptr_reg;
    logic            accept;
    logic [NUM_STREAMS-1:0] req;

    assign accept = grant_valid_reg & grant_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
            logic                    en_reg;
            logic [PERIOD_WIDTH-1:0] period_reg;
            logic [PERIOD_WIDTH-1:0] cnt_reg;
            logic [FRAC_WIDTH-1:0]   frac_reg;
            logic [FRAC_WIDTH-1:0]   acc_reg;
            logic                    extra_reg;
            logic [CW-1:0]           credit_reg;
            logic [CW-1:0]           credit_next;
            logic                    hit;
            logic                    active;
            logic                    tick;
            logic                    dec;
            logic                    lost;
            logic [PERIOD_WIDTH-1:0] limit;
            logic [FRAC_WIDTH:0]     acc_sum;

            assign hit     = cfg_we && (cfg_stream == SW'(gi));
            assign active  = en_reg && (period_reg != '0);
            assign limit   = period_reg - PERIOD_WIDTH'(1) + PERIOD_WIDTH'(extra_reg);
            assign tick    = active && (cnt_reg == limit);
            assign acc_sum = {1'b0, acc_reg} + {1'b0, frac_reg};
            // Decrement only real credit: a grant issued before a clearing write must not underflow.
            assign dec     = accept && (grant_stream_reg == SW'(gi)) && (credit_reg != '0);
            assign lost    = tick && !dec && (credit_reg == CW'(CREDIT_MAX));

            always_comb begin
                credit_next = credit_reg;
                if (tick && !dec && !lost) begin
                    credit_next = credit_reg + CW'(1);
                end else if (dec && !tick) begin
                    credit_next = credit_reg - CW'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_reg     <= 1'b0;
                    period_reg <= '0;
                    frac_reg   <= '0;
                    cnt_reg    <= '0;
                    acc_reg    <= '0;
                    extra_reg  <= 1'b0;
                    credit_reg <= '0;
                end else if (hit) begin
                    en_reg     <= cfg_enable;
                    period_reg <= cfg_period;
                    frac_reg   <= cfg_frac;
                    cnt_reg    <= '0;
                    acc_reg    <= '0;
                    extra_reg  <= 1'b0;
                    credit_reg <= '0;
                end else begin
                    credit_reg <= credit_next;
                    if (!active) begin
                        cnt_reg <= '0;
                    end else if (tick) begin
                        cnt_reg   <= '0;
                        acc_reg   <= acc_sum[FRAC_WIDTH-1:0];
                        extra_reg <= acc_sum[FRAC_WIDTH];
                    end else begin
                        cnt_reg <= cnt_reg + PERIOD_WIDTH'(1);
                    end
                end
            end

            assign req[gi] = active && (credit_reg != '0);

`ifdef TX_SCHED_OVERFLOW_EN
            logic ovf_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_reg <= 1'b0;
                end else if (hit) begin
                    ovf_reg <= 1'b0;
                end else if (lost) begin
                    ovf_reg <= 1'b1;
                end
            end
            assign overflow[gi] = ovf_reg;
`endif
        end
    endgenerate

`ifndef TX_SCHED_OVERFLOW_EN
    assign overflow = '0;
`endif

    // First requesting stream at or after rr_ptr, wrapping at NUM_STREAMS.
    logic          pick_found;
    logic [SW-1:0] pick;
    always_comb begin
        logic [SW:0] idx_w;
        pick_found = 1'b0;
        pick       = '0;
        idx_w      = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            idx_w = {1'b0, rr_ptr_reg} + (SW+1)'(k);
            if (idx_w >= (SW+1)'(NUM_STREAMS)) begin
                idx_w = idx_w - (SW+1)'(NUM_STREAMS);
            end
            if (!pick_found && req[idx_w[SW-1:0]]) begin
                pick_found = 1'b1;
                pick       = idx_w[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            grant_valid_reg  <= 1'b0;
            grant_stream_reg <= '0;
            rr_ptr_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_stream_reg <= pick;
                        grant_valid_reg  <= 1'b1;
                        state_reg        <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        grant_valid_reg <= 1'b0;
                        rr_ptr_reg      <= (grant_stream_reg == SW'(NUM_STREAMS - 1)) ?
                                           '0 : grant_stream_reg + SW'(1);
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant_valid  = grant_valid_reg;
    assign grant_stream = grant_stream_reg;
endmodule
